// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Build option: UART_RX_PARITY_EN adds an even-parity state to the frame FSM.
package uart_pkg;

    // Character width carried on the serial line and through the FIFO.
    localparam int DATA_W = 8;

    // Clock cycles per bit for a 25 MHz core clock at 115200 baud.
    localparam int DEFAULT_CLK_DIV = 217;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO. rd_data is registered and always shows
// the head entry while non-empty; it holds its last value once drained.
// A pop is ignored when empty; a push while full only lands if a pop in the
// same cycle frees the head slot.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic [W-1:0]  head_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Look ahead at the next head so rd_data is correct the cycle after any update
    always_comb begin
        rd_ptr_nxt = rd_ptr + AW'(pop_ok);
        count_nxt  = count + CW'(push_ok) - CW'(pop_ok);
        head_nxt   = mem[rd_ptr_nxt];
        // The entry being written this cycle becomes the head: bypass the array
        if (push_ok && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = push_data;
        end
    end

    // Storage array; contents are only observed once written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr + AW'(push_ok);
            count  <= count_nxt;
            if (count_nxt != '0) begin
                rd_data <= head_nxt;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: pin synchroniser, mid-bit sampling frame FSM,
// receive FIFO, sticky error flags and a registered interrupt.
// Build option: define UART_RX_PARITY_EN for 8E1 framing with a par_err flag;
// the default build frames 8N1.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_in,
    input  logic                        sys_rstn,
    input  logic                        uart_rxd,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rx_valid,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        overrun,
    output logic                        frame_err,
    input  logic                        clr_err,
    input  logic                        irq_en,
`ifdef UART_RX_PARITY_EN
    output logic                        par_err,
`endif
    output logic                        irq
);

    localparam int                CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LOAD  = CNT_W'(CLK_DIV - 1);

    logic              rxd_meta;
    logic              rxd_s;
    rx_state_t         state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              push;
    logic              tick;
    logic              frame_set;
    logic              overrun_set;
    logic              fifo_full;
    logic              fifo_empty;
    logic              err_any;
`ifdef UART_RX_PARITY_EN
    logic              par_bad;
    logic              par_set;
`endif

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
        end
    end

    assign tick      = (baud_cnt == '0);
    assign frame_set = (state == STOP) && tick && !rxd_s;
`ifdef UART_RX_PARITY_EN
    // Even parity: data ones plus the parity bit must be even
    assign par_set   = (state == PARITY) && tick && ((^shift_reg) ^ rxd_s);
`endif

    // Frame FSM: half-bit wait to the start-bit centre, then one bit period per sample
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            push      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            push <= 1'b0;
            if ((state != IDLE) && (state != BREAK_WAIT) && !tick) begin
                baud_cnt <= baud_cnt - CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        baud_cnt <= HALF_LOAD;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rxd_s) begin
                            baud_cnt <= BIT_LOAD;
                            bit_idx  <= '0;
                            state    <= DATA;
                        end else begin
                            // Low pulse shorter than half a bit: treat as noise
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {rxd_s, shift_reg[DATA_W-1:1]};
                        baud_cnt  <= BIT_LOAD;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bad  <= par_set;
                        baud_cnt <= BIT_LOAD;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                            push <= !par_bad;
`else
                            push <= 1'b1;
`endif
                            state <= IDLE;
                        end else begin
                            // Low stop bit: drop the byte and wait out any break
                            state <= BREAK_WAIT;
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (sys_rstn),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    assign rx_valid    = !fifo_empty;
    // A same-cycle pop frees the head slot, so only an unpaired push is lost
    assign overrun_set = push && fifo_full && !rd_en;

    // Sticky error flags: a new error in the clearing cycle wins
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            overrun   <= overrun_set | (overrun & !clr_err);
            frame_err <= frame_set | (frame_err & !clr_err);
`ifdef UART_RX_PARITY_EN
            par_err   <= par_set | (par_err & !clr_err);
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign err_any = overrun | frame_err | par_err;
`else
    assign err_any = overrun | frame_err;
`endif

    // Interrupt request, registered one cycle behind its sources
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & (rx_valid | err_any);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: CLK_DIV = 8, FIFO_DEPTH = 4, 40 ns clock.
// Serial frames are driven on the falling clock edge; outputs are sampled on
// the falling edge. Expected bytes flow through exp_q.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int CLK_DIV    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    // Posedges from the start-bit drive to rx_valid observed high, counted by
    // the edge monitor: 9.5 * CLK_DIV + 3 edges, plus the monitor's own offset.
    localparam int EXP_LAT    = (19 * CLK_DIV) / 2 + 3 + 1;

    logic          clk      = 1'b0;
    logic          sys_rstn = 1'b0;
    logic          uart_rxd = 1'b1;
    logic          rd_en    = 1'b0;
    logic          clr_err  = 1'b0;
    logic          irq_en   = 1'b0;
    logic [7:0]    rd_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          overrun;
    logic          frame_err;
    logic          irq;
`ifdef UART_RX_PARITY_EN
    logic          par_err;
`endif

    int            errors    = 0;
    int            checks    = 0;
    int            cyc_m     = 0;
    int            start_cyc = 0;
    int            rise_cyc  = 0;
    logic          valid_d   = 1'b0;
    logic [7:0]    exp_q[$];

    uart_rx_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_in    (clk),
        .sys_rstn  (sys_rstn),
        .uart_rxd  (uart_rxd),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err),
        .irq_en    (irq_en),
`ifdef UART_RX_PARITY_EN
        .par_err   (par_err),
`endif
        .irq       (irq)
    );

    // Clock
    always #20 clk = ~clk;

    // Edge counter and rx_valid rise detector, sampled just after each posedge
    always @(posedge clk) begin
        #1;
        cyc_m = cyc_m + 1;
        if (rx_valid && !valid_d) rise_cyc = cyc_m;
        valid_d = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    // One frame, start edge on a falling clock edge. Optionally pop on the
    // FIFO push cycle, or pulse clr_err on the stop-bit sample cycle.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic pop_at_push, input logic clr_at_stop);
        logic [7:0] head;
        @(negedge clk);
        start_cyc = cyc_m;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        uart_rxd = stop_bit;
        for (int i = 1; i <= CLK_DIV; i++) begin
            @(negedge clk);
            if (i == CLK_DIV - 2 && clr_at_stop) clr_err = 1'b1;
            if (i == CLK_DIV - 1) begin
                clr_err = 1'b0;
                if (pop_at_push) begin
                    head = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    check("collision_head", 32'(rd_data), 32'(head));
                    rd_en = 1'b1;
                end
            end
            if (i == CLK_DIV) rd_en = 1'b0;
        end
    endtask

    // Compare the FIFO head with the scoreboard and pop it
    task automatic pop_check(input string tag);
        logic [7:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset
        #600;
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_count", 32'(rx_count), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        #100;
        sys_rstn = 1'b1;
        repeat (4) @(negedge clk);
        irq_en = 1'b1;

        // Single byte
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check("single_valid", 32'(rx_valid), 32'h1);
        check("single_latency", 32'(rise_cyc - start_cyc), 32'(EXP_LAT));
        check("single_irq_lag", 32'(irq), 32'h0);
        check("single_count", 32'(rx_count), 32'h1);
        @(negedge clk);
        check("single_irq", 32'(irq), 32'h1);
        pop_check("single_data");
        check("single_pop_valid", 32'(rx_valid), 32'h0);
        check("single_pop_irq_lag", 32'(irq), 32'h1);
        @(negedge clk);
        check("single_irq_fall", 32'(irq), 32'h0);

        // Glitch rejection
        uart_rxd = 1'b0;
        repeat (2) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_valid", 32'(rx_valid), 32'h0);
        check("glitch_frame_err", 32'(frame_err), 32'h0);
        check("glitch_overrun", 32'(overrun), 32'h0);
        check("glitch_irq", 32'(irq), 32'h0);

        // Overrun and pointer wrap
        for (int b = 1; b <= 5; b++) begin
            if (b <= FIFO_DEPTH) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 1'b0, 1'b0);
            if (b == FIFO_DEPTH) check("ovr_no_flag_at_full", 32'(overrun), 32'h0);
        end
        check("ovr_count", 32'(rx_count), 32'(FIFO_DEPTH));
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_irq", 32'(irq), 32'h1);
        for (int k = 0; k < 4; k++) pop_check("ovr_read");
        check("ovr_drained", 32'(rx_valid), 32'h0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);
        for (int b = 6; b <= 8; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 1'b0, 1'b0);
        end
        check("wrap_count", 32'(rx_count), 32'h3);
        for (int k = 0; k < 3; k++) pop_check("wrap_read");

        // Push/pop collision at full
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h44);
        send_frame(8'h44, 1'b1, 1'b0, 1'b0);
        check("coll_full", 32'(rx_count), 32'h4);
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1'b1, 1'b0);
        check("coll_overrun", 32'(overrun), 32'h0);
        check("coll_count", 32'(rx_count), 32'h4);
        for (int k = 0; k < 4; k++) pop_check("coll_read");
        check("coll_drained", 32'(rx_valid), 32'h0);

        // Framing error followed by a long break
        send_frame(8'h96, 1'b0, 1'b0, 1'b0);
        check("frm_flag", 32'(frame_err), 32'h1);
        check("frm_no_byte", 32'(rx_count), 32'h0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        repeat (40 * CLK_DIV) @(negedge clk);
        check("brk_single_err", 32'(frame_err), 32'h0);
        check("brk_no_byte", 32'(rx_count), 32'h0);
        uart_rxd = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("brk_recover_count", 32'(rx_count), 32'h1);
        check("brk_recover_data", 32'(rd_data), 32'(exp_q[0]));
        check("brk_recover_flag", 32'(frame_err), 32'h0);
        // Clear asserted on the very cycle a new framing error is detected
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        check("frm_set_wins", 32'(frame_err), 32'h1);
        check("frm_set_wins_count", 32'(rx_count), 32'h1);
        uart_rxd = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);

        // Reset during data bit 4
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        sys_rstn = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_count", 32'(rx_count), 32'h0);
        check("mid_rst_data", 32'(rd_data), 32'h00);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        sys_rstn = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check("post_rst_count", 32'(rx_count), 32'h1);
        check("post_rst_frame_err", 32'(frame_err), 32'h0);
        pop_check("post_rst_data");
        check("post_rst_drained", 32'(rx_valid), 32'h0);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
